// File: rtl/shift_pkg.sv
// Shared encodings for the sequential shifter: shift kinds and FSM states.
package shift_pkg;

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_ROL = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/shift1_stage.sv
// Single one-bit shift step: moves data by one position according to op and
// reports the bit that leaves the word.
module shift1_stage
   import shift_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [1:0]   op,
   input  logic [N-1:0] data,
   output logic [N-1:0] shifted,
   output logic         out_bit
);

   always_comb begin
      shifted = data;
      out_bit = 1'b0;
      case (op)
         OP_SLL: begin
            shifted = {data[N-2:0], 1'b0};
            out_bit = data[N-1];
         end
         OP_SRL: begin
            shifted = {1'b0, data[N-1:1]};
            out_bit = data[0];
         end
         OP_SRA: begin
            shifted = {data[N-1], data[N-1:1]};
            out_bit = data[0];
         end
         OP_ROL: begin
            shifted = {data[N-2:0], data[N-1]};
            out_bit = data[N-1];
         end
         default: begin
            shifted = data;
            out_bit = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: moves the captured operand one bit per clock and
// presents result/carry with a one-cycle done pulse.
module seq_shifter
   import shift_pkg::*;
#(
   parameter int N   = 8,
   parameter int SHW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [1:0]     op,
   input  logic [SHW-1:0] amt,
   input  logic [N-1:0]   A,
   output logic           busy,
   output logic           done,
   output logic [N-1:0]   result,
   output logic           carry
);

   state_t         state;
   state_t         state_next;
   logic [N-1:0]   opnd;
   logic [1:0]     op_r;
   logic [SHW-1:0] cnt;
   logic [N-1:0]   sh_data;
   logic           sh_out;

   shift1_stage #(.N(N)) u_stage (
      .op      (op_r),
      .data    (opnd),
      .shifted (sh_data),
      .out_bit (sh_out)
   );

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = (amt == {SHW{1'b0}}) ? DONE : SHIFT;
            end else begin
               state_next = IDLE;
            end
         end
         SHIFT: begin
            if (cnt == SHW'(1'b1)) begin
               state_next = DONE;
            end else begin
               state_next = SHIFT;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // result/carry are written only on the edge that enters DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         opnd   <= {N{1'b0}};
         op_r   <= 2'b00;
         cnt    <= {SHW{1'b0}};
         result <= {N{1'b0}};
         carry  <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (start) begin
                  opnd <= A;
                  op_r <= op;
                  cnt  <= amt;
                  if (amt == {SHW{1'b0}}) begin
                     result <= A;
                     carry  <= 1'b0;
                  end
               end
            end
            SHIFT: begin
               opnd <= sh_data;
               cnt  <= cnt - SHW'(1'b1);
               if (cnt == SHW'(1'b1)) begin
                  result <= sh_data;
                  carry  <= sh_out;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy = (state == SHIFT) || (state == DONE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: directed plan cases plus random requests
// compared against a whole-shift arithmetic model.
module tb_seq_shifter;

   localparam int N = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [1:0] op = 2'b00;
   logic [2:0] amt = 3'd0;
   logic [7:0] A = 8'h00;
   logic       busy, done, carry;
   logic [7:0] result;

   int total = 0;
   int bad   = 0;

   seq_shifter #(.N(N)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .amt(amt), .A(A),
      .busy(busy), .done(done), .result(result), .carry(carry)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Whole shift computed in one go from the shift rules
   task automatic model(input logic [7:0] a, input logic [1:0] o, input logic [2:0] n,
                        output logic [7:0] res, output logic c);
      int k;
      k = int'(n);
      res = a;
      c   = 1'b0;
      case (o)
         2'b00: begin res = a << k;  if (k != 0) c = a[N-k]; end
         2'b01: begin res = a >> k;  if (k != 0) c = a[k-1]; end
         2'b10: begin res = 8'($signed(a) >>> k); if (k != 0) c = a[k-1]; end
         default: begin
            res = (a << k) | (a >> (N - k));
            if (k != 0) c = res[0];
         end
      endcase
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic run_req(input string tag, input logic [7:0] a_in, input logic [1:0] op_in,
                          input logic [2:0] amt_in, input int pulse_at);
      logic [7:0] exp_r, prev_r;
      logic       exp_c, prev_c;
      int         got;
      model(a_in, op_in, amt_in, exp_r, exp_c);
      prev_r = result;
      prev_c = carry;
      got = 0;
      start = 1'b1; A = a_in; op = op_in; amt = amt_in;
      tick();
      chk({tag, "_busy1"}, busy, 1);
      for (int k = 1; k <= 20; k++) begin
         if (k > 1) tick();
         start = (k == pulse_at);
         A   = (k == pulse_at) ? 8'hFF : 8'($urandom);
         amt = (k == pulse_at) ? 3'd1 : 3'($urandom);
         op  = 2'($urandom);
         if (done) begin
            got = k;
            break;
         end
         chk({tag, "_hold"}, {result, carry}, {prev_r, prev_c});
      end
      start = 1'b0;
      chk({tag, "_lat"}, got, int'(amt_in) + 1);
      chk({tag, "_res"}, result, exp_r);
      chk({tag, "_cy"}, carry, exp_c);
      tick();
      chk({tag, "_pulse"}, {busy, done}, 2'b00);
      chk({tag, "_stable"}, {result, carry}, {exp_r, exp_c});
   endtask

   initial begin
      logic [7:0] er;
      logic       ec;
      int         seen;
      rst = 1'b1;
      tick(); tick();
      chk("rst_state", {busy, done, result, carry}, 11'd0);
      rst = 1'b0;
      tick();

      run_req("sll3",  8'h96, 2'b00, 3'd3, 0);
      chk("sll3_lit", {result, carry}, {8'hB0, 1'b0});
      run_req("sra2",  8'h96, 2'b10, 3'd2, 0);
      chk("sra2_lit", {result, carry}, {8'hE5, 1'b1});
      run_req("srl2",  8'h96, 2'b01, 3'd2, 0);
      chk("srl2_lit", {result, carry}, {8'h25, 1'b1});
      run_req("srl7",  8'h81, 2'b01, 3'd7, 3);
      chk("srl7_lit", {result, carry}, {8'h01, 1'b0});
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("srl7_nodup", {busy, done}, 2'b00);
      end
      run_req("rol1",  8'h81, 2'b11, 3'd1, 0);
      chk("rol1_lit", {result, carry}, {8'h03, 1'b1});
      run_req("amt0",  8'h81, 2'b11, 3'd0, 0);
      chk("amt0_lit", {result, carry}, {8'h81, 1'b0});

      // reset while shifting abandons the request
      start = 1'b1; A = 8'h96; op = 2'b00; amt = 3'd5;
      tick();
      start = 1'b0;
      tick(); tick();
      chk("mid_busy", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst", {busy, done, result, carry}, 11'd0);
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (done || busy) seen++;
      end
      chk("mid_nodone", seen, 0);
      run_req("fresh", 8'h01, 2'b00, 3'd1, 0);
      chk("fresh_lit", result, 8'h02);

      // held start: done every amt+2 = 3 cycles
      start = 1'b1; A = 8'h40; op = 2'b00; amt = 3'd1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk("held_done", done, (k % 3 == 2) ? 1 : 0);
         if (done) chk("held_res", {result, carry}, {8'h80, 1'b0});
      end
      start = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      chk("held_idle", busy, 0);

      for (int i = 0; i < 40; i++) begin
         logic [7:0] ra;
         logic [1:0] ro;
         logic [2:0] rn;
         ra = 8'($urandom);
         ro = 2'($urandom);
         rn = 3'($urandom_range(0, 7));
         run_req("rand", ra, ro, rn, ($urandom_range(0, 3) == 0) ? 2 : 0);
         model(ra, ro, rn, er, ec);
         if ($urandom_range(0, 1) == 1) tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
